// File: rtl/vt_deletion_corrector.sv
// ============================================================================
// Module   : vt_deletion_corrector
// Brief    : Serial single-deletion corrector for q-ary shifted-VT codewords.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vt_deletion_corrector #(
    parameter  int N     = 98,
    parameter  int SYM_W = 2,
    localparam int Q     = 1 << SYM_W,
    localparam int IW    = $clog2(N),
    localparam int DW    = $clog2(2 * Q * N) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [(N-1)*SYM_W-1:0]   word_in,
    input  logic [DW-1:0]            delta_in,
    input  logic [SYM_W:0]           gamma_in,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [IW-1:0]            missing_index,
    output logic [SYM_W-1:0]         missing_digit,
    output logic [N*SYM_W-1:0]       word_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_SUM, S_DECIDE, S_SCAN_F, S_SCAN_B, S_INSERT, S_DONE
    } state_t;

    localparam logic [IW-1:0] c_last_rx = IW'(N - 2);
    localparam logic [IW-1:0] c_last_cw = IW'(N - 1);
    localparam logic [DW-1:0] c_nm1     = DW'(N - 1);
    localparam logic [DW-1:0] c_q       = DW'(Q);

    state_t                   r_state, w_next;
    logic [(N-1)*SYM_W-1:0]   r_word;
    logic [DW-1:0]            r_delta, r_sum, r_acc, r_p;
    logic [SYM_W-1:0]         r_gamma;
    logic [IW-1:0]            r_j, r_idx;
    logic                     r_err;
    logic [N*SYM_W-1:0]       r_xword;

    logic [SYM_W-1:0]         w_y_j, w_y_jm1, w_y_jm2, w_d_j, w_d_jm1, w_gdiff;
    logic [DW-1:0]            w_acc_nxt, w_qoff, w_deltaj;
    logic                     w_go_f, w_go_b, w_hit_f, w_hit_b;
    logic [N*SYM_W-1:0]       w_ins;

    // Neighbouring symbols around the scan pointer; positions below 0 read as 0.
    assign w_y_j    = r_word[r_j*SYM_W +: SYM_W];
    assign w_y_jm1  = (r_j == '0) ? '0 : r_word[(r_j - IW'(1))*SYM_W +: SYM_W];
    assign w_y_jm2  = (r_j < IW'(2)) ? '0 : r_word[(r_j - IW'(2))*SYM_W +: SYM_W];
    assign w_d_j    = w_y_j - w_y_jm1;
    assign w_d_jm1  = w_y_jm1 - w_y_jm2;
    assign w_gdiff  = r_gamma - w_y_jm1;

    assign w_acc_nxt = r_acc + DW'(w_d_j);
    assign w_qoff    = (c_nm1 - DW'(r_j)) << SYM_W;
    assign w_deltaj  = DW'(w_gdiff) + r_p + w_qoff;

    assign w_go_f  = (r_delta < r_sum);
    assign w_go_b  = (r_delta >= r_sum + c_q);
    assign w_hit_f = (w_acc_nxt >= r_delta);
    assign w_hit_b = (w_deltaj == r_delta);

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_ins
            if (k == 0) begin : g_first
                assign w_ins[0 +: SYM_W] = (r_idx == '0) ? r_gamma : r_word[0 +: SYM_W];
            end else if (k == N - 1) begin : g_last
                assign w_ins[k*SYM_W +: SYM_W] = (r_idx == c_last_cw) ? r_gamma
                                               : r_word[(k-1)*SYM_W +: SYM_W];
            end else begin : g_mid
                assign w_ins[k*SYM_W +: SYM_W] =
                    (IW'(k) < r_idx)  ? r_word[k*SYM_W +: SYM_W] :
                    (IW'(k) == r_idx) ? r_gamma :
                                        r_word[(k-1)*SYM_W +: SYM_W];
            end
        end
    endgenerate

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_SUM;
            S_SUM:    if (r_j == c_last_rx) w_next = S_DECIDE;
            S_DECIDE: w_next = w_go_f ? S_SCAN_F : (w_go_b ? S_SCAN_B : S_INSERT);
            S_SCAN_F: if (w_hit_f) w_next = S_INSERT;
            S_SCAN_B: begin
                if (w_hit_b)          w_next = S_INSERT;
                else if (r_j == '0)   w_next = S_DONE;
            end
            S_INSERT: w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word <= '0; r_delta <= '0; r_gamma <= '0; r_sum <= '0;
            r_acc  <= '0; r_p     <= '0; r_j     <= '0; r_idx <= '0;
            r_err  <= 1'b0; r_xword <= '0;
            done   <= 1'b0; err <= 1'b0; missing_index <= '0;
            missing_digit <= '0; word_out <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_word  <= word_in;
                    r_delta <= delta_in;
                    // Class Q encodes digit 0; the mask keeps any class in-alphabet.
                    r_gamma <= gamma_in[SYM_W-1:0] & ~{SYM_W{gamma_in[SYM_W]}};
                    r_j     <= '0;
                    r_sum   <= '0;
                    r_err   <= 1'b0;
                end
                S_SUM: begin
                    r_sum <= r_sum + DW'(w_d_j);
                    if (r_j == c_last_rx) begin
                        r_p   <= r_sum;        // S - d[N-2], seed for the backward scan
                        r_j   <= '0;
                        r_acc <= '0;
                    end else begin
                        r_j <= r_j + IW'(1);
                    end
                end
                S_DECIDE: begin
                    if (w_go_b)       r_j   <= c_last_rx;
                    else if (!w_go_f) r_idx <= c_last_cw;
                end
                S_SCAN_F: begin
                    r_acc <= w_acc_nxt;
                    if (w_hit_f) r_idx <= r_j;
                    else         r_j   <= r_j + IW'(1);
                end
                S_SCAN_B: begin
                    if (w_hit_b) begin
                        r_idx <= r_j;
                    end else if (r_j == '0) begin
                        r_err <= 1'b1;
                    end else begin
                        r_p <= r_p - DW'(w_d_jm1);
                        r_j <= r_j - IW'(1);
                    end
                end
                S_INSERT: r_xword <= w_ins;
                S_DONE: begin
                    done          <= 1'b1;
                    err           <= r_err;
                    missing_index <= r_err ? '0 : r_idx;
                    missing_digit <= r_err ? '0 : r_gamma;
                    word_out      <= r_err ? '0 : r_xword;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vt_deletion_corrector.sv
// ============================================================================
// Module   : tb_vt_deletion_corrector
// Brief    : Self-checking bench for vt_deletion_corrector (N=8, SYM_W=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vt_deletion_corrector;

    localparam int N   = 8;
    localparam int SW  = 2;
    localparam int Q   = 4;
    localparam int IW  = $clog2(N);
    localparam int DW  = $clog2(2 * Q * N) + 1;
    localparam int WIN = (N - 1) * SW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [WIN-1:0]    word_in = '0;
    logic [DW-1:0]     delta_in = '0;
    logic [SW:0]       gamma_in = '0;
    logic              busy, done, err;
    logic [IW-1:0]     missing_index;
    logic [SW-1:0]     missing_digit;
    logic [N*SW-1:0]   word_out;

    int errors = 0;
    int checks = 0;

    vt_deletion_corrector #(.N(N), .SYM_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .word_in(word_in),
        .delta_in(delta_in), .gamma_in(gamma_in), .busy(busy), .done(done),
        .err(err), .missing_index(missing_index), .missing_digit(missing_digit),
        .word_out(word_out)
    );

    always #5 clk = ~clk;

    // Reference: decision rules evaluated with plain integer sums over the word.
    task automatic model(input logic [WIN-1:0] w, input int delta, input int gamma,
                         output int idx, output bit e, output int digit,
                         output logic [N*SW-1:0] xw, output int lat);
        int y[N-1];
        int d[N-1];
        int s, pre, p, yp, dj;
        bit found;
        s = 0;
        for (int i = 0; i < N - 1; i++) y[i] = int'(w[i*SW +: SW]);
        for (int i = 0; i < N - 1; i++) begin
            d[i] = (y[i] - ((i == 0) ? 0 : y[i-1]) + Q) % Q;
            s += d[i];
        end
        digit = gamma % Q;
        e = 1'b0;
        idx = N - 1;
        lat = N + 2;
        if (delta < s) begin
            pre = 0;
            for (int j = 0; j < N - 1; j++) begin
                pre += d[j];
                if (pre >= delta) begin idx = j; break; end
            end
            lat = N + 2 + idx + 1;
        end else if (delta >= s + Q) begin
            found = 1'b0;
            for (int j = N - 2; j >= 0; j--) begin
                p = 0;
                for (int i = 0; i < j; i++) p += d[i];
                yp = (j == 0) ? 0 : y[j-1];
                dj = ((gamma - yp) % Q + Q) % Q + p + Q * (N - 1 - j);
                if (dj == delta) begin idx = j; found = 1'b1; break; end
            end
            if (found) lat = N + 2 + (N - 1 - idx);
            else begin e = 1'b1; idx = 0; digit = 0; lat = 2 * N; end
        end
        xw = '0;
        if (!e) begin
            for (int k = 0; k < N; k++) begin
                if (k < idx)       xw[k*SW +: SW] = SW'(y[k]);
                else if (k == idx) xw[k*SW +: SW] = SW'(digit);
                else               xw[k*SW +: SW] = SW'(y[k-1]);
            end
        end
    endtask

    // Launches one correction, scrambles inputs after capture, measures start->done.
    task automatic do_op(input logic [WIN-1:0] w, input int delta, input int gamma,
                         output int lat, output bit width_ok, output bit tmo);
        @(posedge clk); #1;
        word_in = w; delta_in = DW'(delta); gamma_in = (SW+1)'(gamma); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        word_in = WIN'($urandom); delta_in = DW'($urandom); gamma_in = (SW+1)'($urandom);
        lat = 0; tmo = 1'b1; width_ok = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (done) begin lat = c; tmo = 1'b0; break; end
        end
        if (!tmo) begin
            @(posedge clk); #1;
            width_ok = !done;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, err} !== 3'b000 || missing_index !== '0 || missing_digit !== '0
            || word_out !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b err=%b idx=%0d dig=%0d word=%h required all 0",
                     busy, done, err, missing_index, missing_digit, word_out);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_spec_cases;
        int ya[N-1] = '{1, 2, 3, 0, 1, 2, 3};
        int dl[5]   = '{3, 8, 13, 11, 8};
        int gm[5]   = '{1, 1, 1, 1, 4};
        int xi[5]   = '{2, 7, 6, 0, 7};
        int xl[5]   = '{13, 10, 11, 16, 10};
        int xe[5]   = '{0, 0, 0, 1, 0};
        int xd[5]   = '{1, 1, 1, 0, 0};
        logic [WIN-1:0] w;
        logic [N*SW-1:0] mw;
        int midx, mdig, mlat, lat;
        bit me, wok, tmo;
        for (int i = 0; i < N - 1; i++) w[i*SW +: SW] = SW'(ya[i]);
        for (int t = 0; t < 5; t++) begin
            model(w, dl[t], gm[t], midx, me, mdig, mw, mlat);
            do_op(w, dl[t], gm[t], lat, wok, tmo);
            checks++;
            if (tmo) begin errors++; $display("FAIL spec%0d timeout: no done in 200 cycles", t); end
            checks++;
            if (lat != xl[t]) begin errors++; $display("FAIL spec%0d latency: got %0d required %0d", t, lat, xl[t]); end
            checks++;
            if (int'(missing_index) != xi[t] || int'(err) != xe[t] || int'(missing_digit) != xd[t]) begin
                errors++;
                $display("FAIL spec%0d result: idx=%0d err=%b dig=%0d required idx=%0d err=%0d dig=%0d",
                         t, missing_index, err, missing_digit, xi[t], xe[t], xd[t]);
            end
            checks++;
            if (word_out !== mw) begin errors++; $display("FAIL spec%0d word: got %h required %h", t, word_out, mw); end
            checks++;
            if (!wok) begin errors++; $display("FAIL spec%0d done_width: done still high, required one-cycle pulse", t); end
        end
    endtask

    task automatic test_random;
        logic [WIN-1:0] w;
        logic [N*SW-1:0] mw;
        int dl, gm, midx, mdig, mlat, lat;
        bit me, wok, tmo;
        for (int t = 0; t < 40; t++) begin
            w  = WIN'({$urandom, $urandom});
            gm = $urandom_range(1, Q);
            dl = $urandom_range(0, Q * N - 1);
            model(w, dl, gm, midx, me, mdig, mw, mlat);
            do_op(w, dl, gm, lat, wok, tmo);
            checks++;
            if (tmo || lat != mlat || !wok) begin
                errors++;
                $display("FAIL rand%0d timing: lat=%0d tmo=%b width_ok=%b required lat=%0d", t, lat, tmo, wok, mlat);
            end
            checks++;
            if (int'(missing_index) != midx || err !== me || int'(missing_digit) != mdig || word_out !== mw) begin
                errors++;
                $display("FAIL rand%0d result: idx=%0d err=%b dig=%0d word=%h required idx=%0d err=%b dig=%0d word=%h (w=%h d=%0d g=%0d)",
                         t, missing_index, err, missing_digit, word_out, midx, me, mdig, mw, w, dl, gm);
            end
        end
    endtask

    task automatic test_start_while_busy;
        int ya[N-1] = '{1, 2, 3, 0, 1, 2, 3};
        logic [WIN-1:0] w;
        int dones;
        for (int i = 0; i < N - 1; i++) w[i*SW +: SW] = SW'(ya[i]);
        @(posedge clk); #1;
        word_in = w; delta_in = DW'(3); gamma_in = 3'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 4 * N; c++) begin
            if (c == 3) begin word_in = '0; delta_in = DW'(8); gamma_in = 3'd4; start = 1'b1; end
            else start = 1'b0;
            @(posedge clk); #1;
            if (done) dones++;
        end
        start = 1'b0;
        checks++;
        if (dones != 1) begin errors++; $display("FAIL busy_start dones: got %0d required 1", dones); end
        checks++;
        if (missing_index !== IW'(2) || missing_digit !== SW'(1)) begin
            errors++;
            $display("FAIL busy_start result: idx=%0d dig=%0d required idx=2 dig=1", missing_index, missing_digit);
        end
    endtask

    task automatic test_rst_mid_sum;
        int dones;
        @(posedge clk); #1;
        word_in = WIN'(14'h1b1b); delta_in = DW'(20); gamma_in = 3'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, err} !== 3'b000 || missing_index !== '0 || missing_digit !== '0
            || word_out !== '0) begin
            errors++;
            $display("FAIL rst_mid: busy=%b done=%b err=%b idx=%0d dig=%0d word=%h required all 0",
                     busy, done, err, missing_index, missing_digit, word_out);
        end
        @(negedge clk) rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 3 * N; c++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        checks++;
        if (dones != 0) begin errors++; $display("FAIL rst_abort: %0d busy/done cycles after reset, required 0", dones); end
    endtask

    initial begin
        test_reset();
        test_spec_cases();
        test_random();
        test_start_while_busy();
        test_rst_mid_sum();
        test_spec_cases();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
